vxe_axi4mst_biu: RTL and testbench

- Single-beat AXI4 master bus interface unit. Converts a simple client request/response interface into AXI4 write and read transactions.
- Used by VxEngine blocks that fetch or store data over the system AXI4 fabric.
- Read and write paths are independent and may run concurrently. Each path has at most one outstanding transaction.

---
 rtl/vxe_axi4mst_biu.sv | 250 +++++++++++++++++++++++++
 tb/tb_vxe_axi4mst_biu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vxe_axi4mst_biu.sv
// Single-beat AXI4 master BIU: client write/read requests to independent AXI4 write/read FSMs.
// Optional VXE_AXI4MST_RESP_CHECK_EN: also flag BID/RID mismatch and missing RLAST as errors.
module vxe_axi4mst_biu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                    S_AXI4_ACLK,
  input  logic                    S_AXI4_ARESETn,
  output logic [ID_WIDTH-1:0]     M_AXI4_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI4_AWADDR,
  output logic [7:0]              M_AXI4_AWLEN,
  output logic [2:0]              M_AXI4_AWSIZE,
  output logic [1:0]              M_AXI4_AWBURST,
  output logic                    M_AXI4_AWLOCK,
  output logic [3:0]              M_AXI4_AWCACHE,
  output logic [2:0]              M_AXI4_AWPROT,
  output logic                    M_AXI4_AWVALID,
  input  logic                    M_AXI4_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI4_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI4_WSTRB,
  output logic                    M_AXI4_WLAST,
  output logic                    M_AXI4_WVALID,
  input  logic                    M_AXI4_WREADY,
  input  logic [ID_WIDTH-1:0]     M_AXI4_BID,
  input  logic [1:0]              M_AXI4_BRESP,
  input  logic                    M_AXI4_BVALID,
  output logic                    M_AXI4_BREADY,
  output logic [ID_WIDTH-1:0]     M_AXI4_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI4_ARADDR,
  output logic [7:0]              M_AXI4_ARLEN,
  output logic [2:0]              M_AXI4_ARSIZE,
  output logic [1:0]              M_AXI4_ARBURST,
  output logic                    M_AXI4_ARLOCK,
  output logic [3:0]              M_AXI4_ARCACHE,
  output logic [2:0]              M_AXI4_ARPROT,
  output logic                    M_AXI4_ARVALID,
  input  logic                    M_AXI4_ARREADY,
  input  logic [ID_WIDTH-1:0]     M_AXI4_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI4_RDATA,
  input  logic [1:0]              M_AXI4_RRESP,
  input  logic                    M_AXI4_RLAST,
  input  logic                    M_AXI4_RVALID,
  output logic                    M_AXI4_RREADY,
  input  logic                    biu_wreq,
  input  logic [ADDR_WIDTH-1:0]   biu_waddr,
  input  logic [DATA_WIDTH-1:0]   biu_wdata,
  input  logic [DATA_WIDTH/8-1:0] biu_wben,
  output logic                    biu_wready,
  output logic                    biu_wdone,
  output logic                    biu_werror,
  input  logic                    biu_rreq,
  input  logic [ADDR_WIDTH-1:0]   biu_raddr,
  output logic                    biu_rready,
  output logic                    biu_rdone,
  output logic [DATA_WIDTH-1:0]   biu_rdata,
  output logic                    biu_rerror
);

  localparam logic [ID_WIDTH-1:0] AxiId = ID_WIDTH'(AXI_ID);
  localparam logic [2:0]          Size  = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  assign M_AXI4_AWID    = AxiId;
  assign M_AXI4_AWLEN   = 8'd0;
  assign M_AXI4_AWSIZE  = Size;
  assign M_AXI4_AWBURST = 2'b01;
  assign M_AXI4_AWLOCK  = 1'b0;
  assign M_AXI4_AWCACHE = 4'b0011;
  assign M_AXI4_AWPROT  = 3'd0;
  assign M_AXI4_WLAST   = 1'b1;
  assign M_AXI4_ARID    = AxiId;
  assign M_AXI4_ARLEN   = 8'd0;
  assign M_AXI4_ARSIZE  = Size;
  assign M_AXI4_ARBURST = 2'b01;
  assign M_AXI4_ARLOCK  = 1'b0;
  assign M_AXI4_ARCACHE = 4'b0011;
  assign M_AXI4_ARPROT  = 3'd0;

  logic b_err, r_err;
`ifdef VXE_AXI4MST_RESP_CHECK_EN
  assign b_err = M_AXI4_BRESP[1] | (M_AXI4_BID != AxiId);
  assign r_err = M_AXI4_RRESP[1] | (M_AXI4_RID != AxiId) | ~M_AXI4_RLAST;
  logic unused_resp;
  assign unused_resp = ^{M_AXI4_BRESP[0], M_AXI4_RRESP[0]};
`else
  assign b_err = M_AXI4_BRESP[1];
  assign r_err = M_AXI4_RRESP[1];
  logic unused_resp;
  assign unused_resp = ^{M_AXI4_BID, M_AXI4_RID, M_AXI4_RLAST, M_AXI4_BRESP[0], M_AXI4_RRESP[0]};
`endif

  // Write path
  state_e                  w_state_q, w_state_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    wdone_q, wdone_d, werror_q, werror_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;

  always_comb begin
    w_state_d = w_state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wdone_d   = 1'b0;
    werror_d  = 1'b0;
    case (w_state_q)
      StIdle: begin
        if (biu_wreq) begin
          awaddr_d  = biu_waddr;
          wdata_d   = biu_wdata;
          wstrb_d   = biu_wben;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        // AW and W complete independently; leave once both have gone
        awvalid_d = awvalid_q & ~M_AXI4_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI4_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d  = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp: begin
        if (M_AXI4_BVALID) begin
          bready_d  = 1'b0;
          wdone_d   = 1'b1;
          werror_d  = b_err;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge S_AXI4_ACLK or negedge S_AXI4_ARESETn) begin
    if (!S_AXI4_ARESETn) begin
      w_state_q <= StIdle;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wdone_q   <= 1'b0;
      werror_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wdone_q   <= wdone_d;
      werror_q  <= werror_d;
    end
  end

  assign M_AXI4_AWADDR  = awaddr_q;
  assign M_AXI4_AWVALID = awvalid_q;
  assign M_AXI4_WDATA   = wdata_q;
  assign M_AXI4_WSTRB   = wstrb_q;
  assign M_AXI4_WVALID  = wvalid_q;
  assign M_AXI4_BREADY  = bready_q;
  assign biu_wready     = (w_state_q == StIdle);
  assign biu_wdone      = wdone_q;
  assign biu_werror     = werror_q;

  // Read path
  state_e                r_state_q, r_state_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  rdone_q, rdone_d, rerror_q, rerror_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    r_state_d = r_state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rdone_d   = 1'b0;
    rerror_d  = 1'b0;
    case (r_state_q)
      StIdle: begin
        if (biu_rreq) begin
          araddr_d  = biu_raddr;
          arvalid_d = 1'b1;
          r_state_d = StIssue;
        end
      end
      StIssue: begin
        if (M_AXI4_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = StResp;
        end
      end
      StResp: begin
        if (M_AXI4_RVALID) begin
          rready_d  = 1'b0;
          rdata_d   = M_AXI4_RDATA;
          rdone_d   = 1'b1;
          rerror_d  = r_err;
          r_state_d = StIdle;
        end
      end
      default: r_state_d = StIdle;
    endcase
  end

  always_ff @(posedge S_AXI4_ACLK or negedge S_AXI4_ARESETn) begin
    if (!S_AXI4_ARESETn) begin
      r_state_q <= StIdle;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rdone_q   <= 1'b0;
      rerror_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rdone_q   <= rdone_d;
      rerror_q  <= rerror_d;
    end
  end

  assign M_AXI4_ARADDR  = araddr_q;
  assign M_AXI4_ARVALID = arvalid_q;
  assign M_AXI4_RREADY  = rready_q;
  assign biu_rready     = (r_state_q == StIdle);
  assign biu_rdone      = rdone_q;
  assign biu_rdata      = rdata_q;
  assign biu_rerror     = rerror_q;

endmodule

// File: tb/tb_vxe_axi4mst_biu.sv
// Bench for vxe_axi4mst_biu: configurable AXI slave model, expected completions queued at issue
// and checked by a separate monitor on each done pulse.
module tb_vxe_axi4mst_biu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  awid, arid, awlen, arlen, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  awcache, arcache, wstrb;
  logic        wreq, wrdy, wdone, werror, rreq, rrdy, rdone, rerror;
  logic [31:0] waddr_c, wdata_c, raddr_c, rdata_c;
  logic [3:0]  wben_c;

  always #5 clk = ~clk;

  vxe_axi4mst_biu dut (
    .S_AXI4_ACLK(clk), .S_AXI4_ARESETn(rstn),
    .M_AXI4_AWID(awid), .M_AXI4_AWADDR(awaddr), .M_AXI4_AWLEN(awlen), .M_AXI4_AWSIZE(awsize),
    .M_AXI4_AWBURST(awburst), .M_AXI4_AWLOCK(awlock), .M_AXI4_AWCACHE(awcache),
    .M_AXI4_AWPROT(awprot), .M_AXI4_AWVALID(awvalid), .M_AXI4_AWREADY(awready),
    .M_AXI4_WDATA(wdata), .M_AXI4_WSTRB(wstrb), .M_AXI4_WLAST(wlast), .M_AXI4_WVALID(wvalid),
    .M_AXI4_WREADY(wready), .M_AXI4_BID(bid), .M_AXI4_BRESP(bresp), .M_AXI4_BVALID(bvalid),
    .M_AXI4_BREADY(bready), .M_AXI4_ARID(arid), .M_AXI4_ARADDR(araddr), .M_AXI4_ARLEN(arlen),
    .M_AXI4_ARSIZE(arsize), .M_AXI4_ARBURST(arburst), .M_AXI4_ARLOCK(arlock),
    .M_AXI4_ARCACHE(arcache), .M_AXI4_ARPROT(arprot), .M_AXI4_ARVALID(arvalid),
    .M_AXI4_ARREADY(arready), .M_AXI4_RID(rid), .M_AXI4_RDATA(rdata), .M_AXI4_RRESP(rresp),
    .M_AXI4_RLAST(rlast), .M_AXI4_RVALID(rvalid), .M_AXI4_RREADY(rready),
    .biu_wreq(wreq), .biu_waddr(waddr_c), .biu_wdata(wdata_c), .biu_wben(wben_c),
    .biu_wready(wrdy), .biu_wdone(wdone), .biu_werror(werror),
    .biu_rreq(rreq), .biu_raddr(raddr_c), .biu_rready(rrdy), .biu_rdone(rdone),
    .biu_rdata(rdata_c), .biu_rerror(rerror)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave configuration
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  logic        rlast_cfg = 1'b1;

  // Slave model: everything driven on negedge; *_hs marks a handshake at the coming posedge
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_got, w_got, ar_got, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bid = 0; bresp = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        continue;
      end
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if (ar_hs) ar_got = 1;
      if (b_hs) begin bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0; end
      if (r_hs) begin rvalid = 0; ar_got = 0; r_cnt = 0; end
      awready = awvalid && (aw_cnt >= aw_delay); aw_cnt = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && (w_cnt >= w_delay);    w_cnt  = wvalid ? w_cnt + 1 : 0;
      arready = arvalid && (ar_cnt >= ar_delay); ar_cnt = arvalid ? ar_cnt + 1 : 0;
      if (aw_got && w_got && !bvalid) begin
        if (b_cnt >= b_delay) begin bvalid = 1; bresp = bresp_cfg; bid = 8'h00; end
        else b_cnt++;
      end
      if (ar_got && !rvalid) begin
        if (r_cnt >= r_delay) begin
          rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; rid = 8'h00; rlast = rlast_cfg;
        end else r_cnt++;
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      b_hs  = bvalid && bready;
      r_hs  = rvalid && rready;
    end
  end

  // Scoreboard
  logic        wq[$];
  logic [32:0] rq[$];
  logic [31:0] exp_awaddr, exp_wdata, exp_araddr;
  logic [3:0]  exp_wstrb;
  time         t_wdone = 0, t_rdone = 0;

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (wdone) begin
          t_wdone = $time;
          if (wq.size() == 0) check("unexpected_wdone", 1, 0);
          else check("werror", werror, wq.pop_front());
        end
        if (rdone) begin
          t_rdone = $time;
          if (rq.size() == 0) check("unexpected_rdone", 1, 0);
          else begin
            e = rq.pop_front();
            check("rdata", rdata_c, e[31:0]);
            check("rerror", rerror, e[32]);
          end
        end
        if (awvalid) check("awaddr", awaddr, exp_awaddr);
        if (wvalid) check("wdata_wstrb", {wdata, wstrb}, {exp_wdata, exp_wstrb});
        if (arvalid) check("araddr", araddr, exp_araddr);
      end
    end
  end

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic exp_err, input bit expect_done);
    int n = 0;
    while (!wrdy && n < 100) begin @(negedge clk); n++; end
    if (!wrdy) check("wready_timeout", 0, 1);
    else begin
      exp_awaddr = a; exp_wdata = d; exp_wstrb = be;
      if (expect_done) wq.push_back(exp_err);
      wreq = 1; waddr_c = a; wdata_c = d; wben_c = be;
      @(negedge clk);
      wreq = 0;
    end
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
    int n = 0;
    while (!rrdy && n < 100) begin @(negedge clk); n++; end
    if (!rrdy) check("rready_timeout", 0, 1);
    else begin
      exp_araddr = a;
      rq.push_back({exp_err, d});
      rreq = 1; raddr_c = a;
      @(negedge clk);
      rreq = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(wq.size() == 0 && rq.size() == 0 && wrdy && rrdy) && n < 200) begin
      @(negedge clk); n++;
    end
    check("idle_timeout", (n < 200), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    logic rlast_err;
    wreq = 0; rreq = 0; waddr_c = 0; wdata_c = 0; wben_c = 0; raddr_c = 0;
    exp_awaddr = 0; exp_wdata = 0; exp_wstrb = 0; exp_araddr = 0;
    repeat (3) @(negedge clk);
    check("reset_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("reset_pulses", {wdone, werror, rdone, rerror}, 4'b0);
    check("reset_rdata", rdata_c, 32'h0);
    check("reset_ready", {wrdy, rrdy}, 2'b11);
    check("const_aw", {awid, awlen, awsize, awburst, awlock, awcache, awprot, wlast},
          {8'h0, 8'h0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 1'b1});
    check("const_ar", {arid, arlen, arsize, arburst, arlock, arcache, arprot},
          {8'h0, 8'h0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0});
    rstn = 1;
    @(negedge clk);

    // Zero-wait write: done pulse at cycle 3 after acceptance
    issue_write(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    check("w1_valid_c1", {awvalid, wvalid, wrdy}, 3'b110);
    n = 1;
    while (!wdone && n < 50) begin @(negedge clk); n++; end
    check("w1_latency", n, 3);
    wait_idle();

    // AWREADY late by 3 cycles
    aw_delay = 3;
    issue_write(32'h104, 32'hCAFEF00D, 4'h3, 1'b0, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("w2_held", {awvalid, wvalid, bready}, 3'b100);
    end
    @(negedge clk);
    check("w2_bready", {awvalid, wvalid, bready}, 3'b001);
    wait_idle();
    aw_delay = 0;

    // Response codes: EXOKAY ok, SLVERR/DECERR flagged
    bresp_cfg = 2'b01; issue_write(32'h108, 32'h1, 4'h1, 1'b0, 1'b1); wait_idle();
    bresp_cfg = 2'b10; issue_write(32'h10C, 32'h2, 4'h2, 1'b1, 1'b1); wait_idle();
    bresp_cfg = 2'b11; issue_write(32'h110, 32'h3, 4'h4, 1'b1, 1'b1); wait_idle();
    bresp_cfg = 2'b00;

    // Read with SLVERR; data must hold afterwards
    rdata_cfg = 32'h12345678; rresp_cfg = 2'b10;
    issue_read(32'h200, 32'h12345678, 1'b1);
    wait_idle();
    rdata_cfg = 32'h0BADBEEF;
    repeat (5) @(negedge clk);
    check("rdata_hold", rdata_c, 32'h12345678);
    rresp_cfg = 2'b01; rdata_cfg = 32'hA5A5A5A5;
    issue_read(32'h204, 32'hA5A5A5A5, 1'b0); wait_idle();
    rresp_cfg = 2'b00;

    // Concurrent write and read, R returns before B
    b_delay = 3; r_delay = 0; rdata_cfg = 32'h55AA55AA;
    fork
      issue_write(32'h300, 32'h11223344, 4'hC, 1'b0, 1'b1);
      issue_read(32'h400, 32'h55AA55AA, 1'b0);
    join
    wait_idle();
    check("conc_order", (t_rdone < t_wdone), 1);
    b_delay = 0;

    // Reset while write stuck in ISSUE: no completion
    aw_delay = 50;
    issue_write(32'h500, 32'h99, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 0;
    #1;
    check("rst_mid_valids", {awvalid, wvalid, bready}, 3'b000);
    check("rst_mid_ready", wrdy, 1);
    repeat (3) @(negedge clk);
    rstn = 1;
    aw_delay = 0;
    repeat (10) @(negedge clk);
    check("rst_no_wdone", wq.size(), 0);

    // Missing RLAST only flagged with response checking enabled
`ifdef VXE_AXI4MST_RESP_CHECK_EN
    rlast_err = 1'b1;
`else
    rlast_err = 1'b0;
`endif
    rlast_cfg = 1'b0; rdata_cfg = 32'h0F0F0F0F;
    issue_read(32'h600, 32'h0F0F0F0F, rlast_err);
    wait_idle();
    rlast_cfg = 1'b1;

    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
